// File: rtl/arbiter_pkg.sv
// Shared types for the request arbiter.
// Build option: ARBITER_ROUND_ROBIN_EN selects round-robin instead of fixed priority.
package arbiter_pkg;

  typedef enum logic {ST_IDLE, ST_OFFER} arb_state_t;

endpackage

// File: rtl/priority_encoder.sv
// Combinational lowest-set-bit encoder over 2**P_width inputs, with an any-bit flag.
module priority_encoder #(
  parameter int P_width = 3
) (
  input  logic [2**P_width-1:0] req_i,
  output logic [P_width-1:0]    idx_o,
  output logic                  any_o
);

  always_comb begin
    idx_o = '0;
    any_o = |req_i;
    // Scan downward so the lowest set index is the last one written.
    for (int i = 2**P_width - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = P_width'(i);
    end
  end

endmodule

// File: rtl/request_arbiter.sv
// Sticky request collector with valid/ready offer of one pending line index.
// Build option: ARBITER_ROUND_ROBIN_EN (round-robin); default is fixed lowest-index priority.
module request_arbiter
  import arbiter_pkg::*;
#(
  parameter  int P_width    = 3,
  localparam int P_up_width = 2**P_width
) (
  input  logic                  I_clock,
  input  logic                  I_reset_n,
  input  logic [P_up_width-1:0] I_request,
  input  logic [P_up_width-1:0] I_mask,
  input  logic                  I_ready,
  output logic                  O_valid,
  output logic [P_width-1:0]    O_index,
  output logic [P_up_width-1:0] O_pending
);

  arb_state_t            state_q;
  logic                  valid_q;
  logic [P_width-1:0]    index_q;
  logic [P_up_width-1:0] pending_q, pending_d;
  logic [P_up_width-1:0] clr, eligible, enc_in;
  logic [P_width-1:0]    enc_idx, sel;
  logic                  any, accept;

  assign accept = valid_q & I_ready;

  always_comb begin
    clr = '0;
    if (accept) clr = P_up_width'(1) << index_q;
  end

  // Set wins over clear: a line re-requested in its accept cycle stays pending.
  assign pending_d = (pending_q & ~clr) | I_request;
  assign eligible  = pending_d & I_mask;

`ifdef ARBITER_ROUND_ROBIN_EN
  logic [P_width-1:0]      ptr_q;
  logic [2*P_up_width-1:0] dbl;

  // Rotate so the pointer position lands on bit 0, encode, then undo the rotation.
  assign dbl    = {eligible, eligible} >> ptr_q;
  assign enc_in = dbl[P_up_width-1:0];
  assign sel    = enc_idx + ptr_q;

  always_ff @(posedge I_clock) begin
    if (!I_reset_n)  ptr_q <= '0;
    else if (accept) ptr_q <= index_q + P_width'(1);
  end
`else
  assign enc_in = eligible;
  assign sel    = enc_idx;
`endif

  priority_encoder #(.P_width(P_width)) u_penc (
    .req_i (enc_in),
    .idx_o (enc_idx),
    .any_o (any)
  );

  always_ff @(posedge I_clock) begin
    if (!I_reset_n) begin
      state_q   <= ST_IDLE;
      valid_q   <= 1'b0;
      index_q   <= '0;
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
      case (state_q)
        ST_IDLE: begin
          if (any) begin
            index_q <= sel;
            valid_q <= 1'b1;
            state_q <= ST_OFFER;
          end
        end
        ST_OFFER: begin
          // The offer is held until taken, regardless of mask or pending changes.
          if (I_ready) begin
            if (any) begin
              index_q <= sel;
            end else begin
              valid_q <= 1'b0;
              state_q <= ST_IDLE;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign O_valid   = valid_q;
  assign O_index   = index_q;
  assign O_pending = pending_q;

endmodule

// File: tb/tb_request_arbiter.sv
// Directed bench for request_arbiter (P_width=3) with a grant scoreboard and monitor.
module tb_request_arbiter;

  localparam int W = 3;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req, mask, pend;
  logic         rdy, vld;
  logic [W-1:0] idx;

  int drv_chk = 0, drv_err = 0;
  int mon_chk = 0, mon_err = 0;
  int tot_chk, tot_err;
  int exp_q[$];

  always #5 clk = ~clk;

  request_arbiter #(.P_width(W)) dut (
    .I_clock   (clk),
    .I_reset_n (rst_n),
    .I_request (req),
    .I_mask    (mask),
    .I_ready   (rdy),
    .O_valid   (vld),
    .O_index   (idx),
    .O_pending (pend)
  );

  // Monitor: every handshake seen mid-cycle pops one expected index.
  always @(negedge clk) begin
    if (rst_n && vld && rdy) begin
      mon_chk++;
      if (exp_q.size() == 0) begin
        mon_err++;
        $display("FAIL grant: unexpected index %0d, none expected", idx);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (idx !== W'(e)) begin
          mon_err++;
          $display("FAIL grant: index %0d, expected %0d", idx, e);
        end
      end
    end
  end

  task automatic cyc(input logic [N-1:0] r, input logic [N-1:0] m, input logic rd);
    req  = r;
    mask = m;
    rdy  = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    drv_chk++;
    if (act !== exp) begin
      drv_err++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; req = '0; mask = '0; rdy = 1'b0;

    // 1. reset wins over requests; first cycle after release captures them
    cyc(8'hFF, 8'h00, 1'b0);
    chk("rst_valid0", int'(vld), 0);  chk("rst_pend0", int'(pend), 0);
    cyc(8'hFF, 8'h00, 1'b0);
    chk("rst_valid1", int'(vld), 0);  chk("rst_pend1", int'(pend), 0);
    chk("rst_index", int'(idx), 0);
    rst_n = 1'b1;
    cyc(8'hFF, 8'h00, 1'b0);
    chk("rel_pend", int'(pend), 'hFF); chk("rel_valid", int'(vld), 0);
    rst_n = 1'b0;
    cyc(8'h00, 8'h00, 1'b0);
    rst_n = 1'b1;

    // 2. two requests drained back to back
    exp_q.push_back(2); exp_q.push_back(5);
    cyc(8'h24, 8'hFF, 1'b1);
    chk("t2_valid", int'(vld), 1); chk("t2_idx2", int'(idx), 2);
    cyc(8'h00, 8'hFF, 1'b1);
    chk("t2_idx5", int'(idx), 5);
    cyc(8'h00, 8'hFF, 1'b1);
    chk("t2_idle", int'(vld), 0);  chk("t2_pend", int'(pend), 0);

    // 3. offer held stable without ready
    exp_q.push_back(3); exp_q.push_back(0);
    cyc(8'h08, 8'hFF, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc(8'h01, 8'hFF, 1'b0);
      chk("t3_hold_idx", int'(idx), 3); chk("t3_hold_vld", int'(vld), 1);
    end
    cyc(8'h00, 8'hFF, 1'b1);
    chk("t3_next", int'(idx), 0);
    cyc(8'h00, 8'hFF, 1'b1);
    chk("t3_idle", int'(vld), 0);

    // 4. set wins over clear in the accept cycle
    exp_q.push_back(4); exp_q.push_back(4);
    cyc(8'h10, 8'hFF, 1'b0);
    cyc(8'h10, 8'hFF, 1'b1);
    chk("t4_pend", int'(pend), 'h10); chk("t4_reoffer", int'(idx), 4);
    chk("t4_vld", int'(vld), 1);
    cyc(8'h00, 8'hFF, 1'b1);
    chk("t4_idle", int'(vld), 0); chk("t4_pend0", int'(pend), 0);

    // 5. masked lines persist, unmasking offers only the eligible one
    exp_q.push_back(7); exp_q.push_back(0);
    cyc(8'h81, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(8'h00, 8'h00, 1'b1);
      chk("t5_nooffer", int'(vld), 0); chk("t5_pend", int'(pend), 'h81);
    end
    cyc(8'h00, 8'h80, 1'b1);
    chk("t5_idx7", int'(idx), 7); chk("t5_vld", int'(vld), 1);
    cyc(8'h00, 8'h80, 1'b1);
    chk("t5_idle", int'(vld), 0); chk("t5_pend01", int'(pend), 'h01);
    cyc(8'h00, 8'hFF, 1'b1);
    chk("t5_idx0", int'(idx), 0);
    cyc(8'h00, 8'hFF, 1'b1);
    chk("t5_done", int'(vld), 0);

    // 6. all lines requested continuously
    rst_n = 1'b0;
    cyc(8'h00, 8'h00, 1'b0);
    rst_n = 1'b1;
`ifdef ARBITER_ROUND_ROBIN_EN
    for (int i = 0; i < 9; i++) exp_q.push_back(i % N);
`else
    for (int i = 0; i < 9; i++) exp_q.push_back(0);
`endif
    for (int i = 0; i < 10; i++) cyc(8'hFF, 8'hFF, 1'b1);
    cyc(8'h00, 8'hFF, 1'b0);
    rst_n = 1'b0;
    cyc(8'h00, 8'h00, 1'b0);
    rst_n = 1'b1;
    cyc(8'h00, 8'h00, 1'b0);

    chk("exp_q_empty", exp_q.size(), 0);

    tot_chk = drv_chk + mon_chk;
    tot_err = drv_err + mon_err;
    $display("Simulation finished: %0d checks, %0d errors", tot_chk, tot_err);
    $finish;
  end

endmodule
